// File: rtl/prim_run_pkg.sv
// Shared types and default widths for the run controller.
// Optional breakpoint support is enabled by defining PRIM_RUN_CTRL_BKPT_EN.
package prim_run_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int CYC_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_STOP  = 2'd0,
    OP_RUN   = 2'd1,
    OP_STEP  = 2'd2,
    OP_RUN_N = 2'd3
  } run_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_COUNT = 2'd3
  } run_state_e;

endpackage

// File: rtl/prim_run_cycle_cnt.sv
// Clearable, enable-gated, wrapping counter of enabled device cycles.
// Used by prim_run_ctrl; no dependency on PRIM_RUN_CTRL_BKPT_EN.
module prim_run_cycle_cnt #(
  parameter int CYC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CYC_W-1:0] cnt_o
);

  logic [CYC_W-1:0] cnt_d;
  logic [CYC_W-1:0] cnt_q;

  // Clear wins over counting; the count wraps silently at 2^CYC_W.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CYC_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_run_ctrl.sv
// Run controller driving primitive_device's enable: free run, single step,
// run-for-N and stop, with an enabled-cycle counter and completion pulse.
// Define PRIM_RUN_CTRL_BKPT_EN to add a result-match breakpoint.
module prim_run_ctrl
  import prim_run_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_cnt_i,
  input  logic [31:0]      result_i,
`ifdef PRIM_RUN_CTRL_BKPT_EN
  input  logic [31:0]      bkpt_val_i,
  input  logic             bkpt_en_i,
  output logic             bkpt_hit_o,
`endif
  output logic             en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CYC_W-1:0] cycles_o
);

  run_state_e       state_d, state_q;
  logic [CNT_W-1:0] remaining_d, remaining_q;
  logic             done_d, done_q;
  logic             err_d, err_q;
  logic             cyc_clr;
  logic             active;
  logic             bkpt_match;
  run_op_e          op;

`ifdef PRIM_RUN_CTRL_BKPT_EN
  logic             bkpt_hit_d, bkpt_hit_q;

  // A breakpoint fires when enabled and the device result equals the target.
  always_comb begin
    bkpt_match = bkpt_en_i && (result_i == bkpt_val_i);
  end
`else
  logic             unused_result;

  assign unused_result = ^result_i;

  // Without breakpoint support nothing can interrupt a run except STOP.
  always_comb begin
    bkpt_match = 1'b0;
  end
`endif

  assign active      = (state_q != ST_IDLE);
  assign cmd_ready_o = ~rst_i;
  assign en_o        = active;
  assign busy_o      = active;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Next-state, budget and pulse logic; STOP/breakpoint and natural completion
  // share one exit path so a coincident STOP yields a single done pulse.
  always_comb begin
    op          = run_op_e'(cmd_op_i);
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cyc_clr     = 1'b0;
`ifdef PRIM_RUN_CTRL_BKPT_EN
    bkpt_hit_d  = bkpt_hit_q;
`endif

    if (active && cmd_valid_i && (op != OP_STOP)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && (op != OP_STOP)) begin
          cyc_clr = 1'b1;
`ifdef PRIM_RUN_CTRL_BKPT_EN
          bkpt_hit_d = 1'b0;
`endif
          case (op)
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: state_d = ST_STEP;
            default: begin
              if (cmd_cnt_i != '0) begin
                state_d     = ST_COUNT;
                remaining_d = cmd_cnt_i;
              end else begin
                done_d = 1'b1;
              end
            end
          endcase
        end
      end
      ST_RUN: begin
        if ((cmd_valid_i && (op == OP_STOP)) || bkpt_match) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
`ifdef PRIM_RUN_CTRL_BKPT_EN
          if (bkpt_match) begin
            bkpt_hit_d = 1'b1;
          end
`endif
        end
      end
      ST_STEP: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        if ((cmd_valid_i && (op == OP_STOP)) || bkpt_match ||
            (remaining_q == CNT_W'(1))) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
`ifdef PRIM_RUN_CTRL_BKPT_EN
          if (bkpt_match) begin
            bkpt_hit_d = 1'b1;
          end
`endif
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
    endcase
  end

  // State, budget and pulse registers with synchronous reset; reset aborts
  // any run without a done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef PRIM_RUN_CTRL_BKPT_EN
  // Sticky breakpoint flag, cleared by the next accepted start command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bkpt_hit_q <= 1'b0;
    end else begin
      bkpt_hit_q <= bkpt_hit_d;
    end
  end

  assign bkpt_hit_o = bkpt_hit_q;
`endif

  prim_run_cycle_cnt #(
    .CYC_W(CYC_W)
  ) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cyc_clr),
    .en_i  (active),
    .cnt_o (cycles_o)
  );

endmodule
